// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM port, execute-stage control and the decoded
// instruction register. The fetch block drives it through the master view.
interface instr_fetch_if #(
  parameter int IW = 35
);
  logic [7:0]    rom_addr;
  logic [IW-1:0] rom_data;
  logic          stall;
  logic          br_taken;
  logic [7:0]    br_target;
  logic [IW-1:0] ir;
  logic          ir_valid;
  logic [7:0]    ir_pc;
  logic [3:0]    op;
  logic [2:0]    cc;
  logic [9:0]    src;
  logic [9:0]    dst;
  logic [7:0]    tgt;
  logic [15:0]   bubble_cnt;

  modport master (
    output rom_addr, ir, ir_valid, ir_pc, op, cc, src, dst, tgt, bubble_cnt,
    input  rom_data, stall, br_taken, br_target
  );

  modport slave (
    input  rom_addr, ir, ir_valid, ir_pc, op, cc, src, dst, tgt, bubble_cnt,
    output rom_data, stall, br_taken, br_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-stage instruction fetch: reads an asynchronous program ROM at the
// PC, registers the word into ir, and handles stall and taken-branch flush.
module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter int         IW       = 35
) (
  input logic          clk,
  input logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_pc;
  logic [IW-1:0] r_ir;
  logic [7:0]    r_ir_pc;
  logic          r_ir_valid;
  logic [15:0]   r_bubble_cnt;

  logic          w_br_take;
  logic          w_valid_next;

  // A branch only counts when it belongs to a real instruction in ir;
  // bubbles (boot, flush) can never redirect the PC.
  always_comb begin
    w_br_take = bus.br_taken && r_ir_valid &&
                ((r_state == S_RUN) || (r_state == S_HOLD));
  end

  // Value ir_valid will take after the coming edge, used by the bubble counter.
  always_comb begin
    w_valid_next = r_ir_valid;
    if (r_state == S_BOOT) begin
      w_valid_next = 1'b0;
    end else if (w_br_take) begin
      w_valid_next = 1'b0;
    end else if (!bus.stall) begin
      w_valid_next = 1'b1;
    end
  end

  // Fetch FSM: branch beats stall, stall freezes everything, otherwise fetch.
  // FLUSH follows the same rules as RUN; its ir_valid is already 0 so the
  // branch qualifier keeps it from being redirected again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= 8'd0;
      r_ir_valid <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
        end
        S_RUN, S_HOLD, S_FLUSH: begin
          if (w_br_take) begin
            r_pc       <= bus.br_target;
            r_ir_valid <= 1'b0;
            r_state    <= S_FLUSH;
          end else if (bus.stall) begin
            r_state <= S_HOLD;
          end else begin
            r_ir       <= bus.rom_data;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + 8'd1;
            r_state    <= S_RUN;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  // Saturating count of cycles that leave a bubble in ir.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= 16'd0;
    end else if (!w_valid_next && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bus.rom_addr   = r_pc;
  assign bus.ir         = r_ir;
  assign bus.ir_valid   = r_ir_valid;
  assign bus.ir_pc      = r_ir_pc;
  assign bus.bubble_cnt = r_bubble_cnt;

  // Instruction fields are plain slices of ir, no extra register stage.
  assign bus.op  = r_ir[34:31];
  assign bus.cc  = r_ir[30:28];
  assign bus.src = r_ir[27:18];
  assign bus.dst = r_ir[17:8];
  assign bus.tgt = r_ir[7:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the stimulus pushes the expected state of
// the fetch outputs for each applied cycle; a monitor pops and compares.
module tb_instr_fetch;

  logic clk;
  logic reset;

  instr_fetch_if #(.IW(35)) bus ();

  instr_fetch #(.RESET_PC(8'd0), .IW(35)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [7:0]  pc;
    logic [7:0]  ra;
    logic [15:0] bub;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Program ROM contents: address 0 holds a GOUT-style word, 200 is blank.
  function automatic logic [34:0] rom_word(input logic [7:0] a);
    if (a == 8'd0)        return 35'h4_0000_0000;
    else if (a == 8'd200) return 35'h0;
    else                  return {a[3:0], a[6:4], 2'b01, a, 2'b10, ~a, a ^ 8'hC3};
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per applied cycle, sampled 1 unit after the edge.
  initial begin
    exp_t e;
    logic [34:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ir_valid", bus.ir_valid, e.v);
        chk("rom_addr", bus.rom_addr, e.ra);
        chk("bubble_cnt", bus.bubble_cnt, e.bub);
        if (e.v) begin
          w = rom_word(e.pc);
          chk("ir_pc", bus.ir_pc, e.pc);
          chk("ir", bus.ir, w);
          chk("op", bus.op, w[34:31]);
          chk("cc", bus.cc, w[30:28]);
          chk("src", bus.src, w[27:18]);
          chk("dst", bus.dst, w[17:8]);
          chk("tgt", bus.tgt, w[7:0]);
        end
        $display("cyc t=%0t stall=%0b br=%0b valid=%0b ir_pc=%0d rom_addr=%0d bub=%0d",
                 $time, bus.stall, bus.br_taken, bus.ir_valid, bus.ir_pc,
                 bus.rom_addr, bus.bubble_cnt);
      end
    end
  end

  // Apply one cycle of inputs and the expected outputs after its edge.
  task automatic step(input logic s, input logic b, input logic [7:0] t,
                      input logic ev, input logic [7:0] epc,
                      input logic [7:0] era, input logic [15:0] eb);
    exp_t e;
    bus.stall     = s;
    bus.br_taken  = b;
    bus.br_target = t;
    e.v = ev; e.pc = epc; e.ra = era; e.bub = eb;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Sequential fetches from first_pc for n cycles with constant bubble count.
  task automatic run(input int n, input logic [7:0] first_pc, input logic [15:0] eb);
    logic [7:0] p;
    p = first_pc;
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 8'd0, 1'b1, p, p + 8'd1, eb);
      p = p + 8'd1;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rom_addr"}, bus.rom_addr, 8'd0);
    chk({tag, "_ir_valid"}, bus.ir_valid, 1'b0);
    chk({tag, "_ir"}, bus.ir, 35'h0);
    chk({tag, "_ir_pc"}, bus.ir_pc, 8'd0);
    chk({tag, "_bubble"}, bus.bubble_cnt, 16'd0);
    chk({tag, "_op"}, bus.op, 4'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = 8'd0;
    @(posedge clk);
    #1;
    chk_reset_state("por");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Boot bubble, then first fetch of word0
    step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 16'd1);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 8'd1, 16'd1);
    // Free run over the full address space, including blank word and wrap
    run(256, 8'd1, 16'd1);
    run(14, 8'd1, 16'd1);
    // Branch at ir_pc=14 to 10; a branch during the flush bubble is ignored
    step(1'b0, 1'b1, 8'd10, 1'b0, 8'd0, 8'd10, 16'd2);
    step(1'b0, 1'b1, 8'd99, 1'b1, 8'd10, 8'd11, 16'd2);
    run(11, 8'd11, 16'd2);
    // Stall three cycles at ir_pc=21
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd21, 8'd22, 16'd2);
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd21, 8'd22, 16'd2);
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd21, 8'd22, 16'd2);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd22, 8'd23, 16'd2);
    // Branch to own address re-fetches it
    step(1'b0, 1'b1, 8'd22, 1'b0, 8'd0, 8'd22, 16'd3);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd22, 8'd23, 16'd3);
    // Stall and branch together: branch wins
    step(1'b1, 1'b1, 8'd110, 1'b0, 8'd0, 8'd110, 16'd4);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd110, 8'd111, 16'd4);
    // Branch taken from HOLD
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd110, 8'd111, 16'd4);
    step(1'b1, 1'b1, 8'd50, 1'b0, 8'd0, 8'd50, 16'd5);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd50, 8'd51, 16'd5);
    // Stall during the flush bubble keeps the bubble and the target
    step(1'b0, 1'b1, 8'd60, 1'b0, 8'd0, 8'd60, 16'd6);
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 8'd60, 16'd7);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd60, 8'd61, 16'd7);
    run(2, 8'd61, 16'd7);
    // Asynchronous reset in the middle of a flush
    step(1'b0, 1'b1, 8'd90, 1'b0, 8'd0, 8'd90, 16'd8);
    bus.br_taken = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_state("async");
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 16'd1);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 8'd1, 16'd1);
    run(3, 8'd1, 16'd1);

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
